// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scanner for the 6-digit timer display.
// It steps one shared seven-segment converter across all digit positions.
// Digits published with `load` are held in staging and are copied into the
// displayed (shadow) copy only at a frame boundary, so a frame never shows a
// mix of old and new values.
//
// Optional feature macro: SEG_SCAN_BLANK_EN. When it is defined, the digit
// enable is blanked for the first BLANK_CYCLES cycles of every slot
// (anti-ghosting). When it is undefined, the enable is one-hot for the whole
// slot and BLANK_CYCLES has no effect.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RESET | first cycle after a synchronous reset; counters are at zero
// ST_SCAN  | normal stepping; the digit enable is driven
// ST_BLANK | start of a slot while blanking is compiled in; enable is forced off
module seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dec_mask,
  input  logic                    load,
  output logic [3:0]              dig_sel,
  output logic                    dec_on,
  input  logic [7:0]              seven_seg_in,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    frame_done
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(NUM_DIGITS);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SLOT_LAST = SW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] BLANK_W   = DW'(BLANK_CYCLES);

`ifdef SEG_SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_RESET,
    ST_SCAN,
    ST_BLANK
  } state_t;

  state_t state_q, state_nxt;

  logic [DW-1:0]           div_cnt, div_nxt;
  logic [SW-1:0]           slot, slot_nxt;
  logic [4*NUM_DIGITS-1:0] stage_dig, shadow_dig, shadow_dig_nxt;
  logic [NUM_DIGITS-1:0]   stage_dp, shadow_dp, shadow_dp_nxt;
  logic                    load_pend;
  logic                    div_wrap, boundary, blank_now;

  // Slot timing, the frame boundary, and the shadow value that will be
  // visible after this edge (the boundary copy and the boundary bypass land
  // here, so the new slot 0 already sees them).
  always_comb begin
    div_wrap       = (div_cnt == DIV_LAST);
    boundary       = div_wrap && (slot == SLOT_LAST);
    div_nxt        = div_wrap ? '0 : div_cnt + 1'b1;
    slot_nxt       = slot;
    shadow_dig_nxt = shadow_dig;
    shadow_dp_nxt  = shadow_dp;
    if (div_wrap) begin
      slot_nxt = (slot == SLOT_LAST) ? '0 : slot + 1'b1;
    end
    if (boundary) begin
      if (load) begin
        shadow_dig_nxt = digits_in;
        shadow_dp_nxt  = dec_mask;
      end else if (load_pend) begin
        shadow_dig_nxt = stage_dig;
        shadow_dp_nxt  = stage_dp;
      end
    end
  end

  assign frame_done = boundary;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_RESET;
    else     state_q <= state_nxt;
  end

  // FSM next state and blanking decision. ST_BLANK tracks "registered
  // div_cnt is inside the blank window". ST_RESET decides from div_cnt directly.
  always_comb begin
    state_nxt = ST_SCAN;
    blank_now = 1'b0;
    case (state_q)
      ST_RESET: blank_now = BLANK_ON && (div_cnt < BLANK_W);
      ST_BLANK: blank_now = 1'b1;
      default:  blank_now = 1'b0;
    endcase
    if (BLANK_ON && (div_nxt < BLANK_W)) state_nxt = ST_BLANK;
  end

  // Counters, staging/shadow copies and the registered pad/converter outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      slot       <= '0;
      stage_dig  <= '0;
      stage_dp   <= '0;
      shadow_dig <= '0;
      shadow_dp  <= '0;
      load_pend  <= 1'b0;
      dig_sel    <= '0;
      dec_on     <= 1'b0;
      seg_out    <= '0;
      an_out     <= '0;
    end else begin
      div_cnt    <= div_nxt;
      slot       <= slot_nxt;
      shadow_dig <= shadow_dig_nxt;
      shadow_dp  <= shadow_dp_nxt;
      if (boundary) begin
        load_pend <= 1'b0;
      end else if (load) begin
        stage_dig <= digits_in;
        stage_dp  <= dec_mask;
        load_pend <= 1'b1;
      end
      dig_sel <= shadow_dig_nxt[4*slot_nxt +: 4];
      dec_on  <= shadow_dp_nxt[slot_nxt];
      seg_out <= seven_seg_in;
      an_out  <= blank_now ? '0 : (NUM_DIGITS'(1) << slot);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with a behavioural seven-segment converter in the
// loop. Expected slot displays are queued by the stimulus and checked by a
// separate monitor whenever a new digit enable appears.
module tb_seg_scan_ctrl;

  localparam int ND = 6;
  localparam int SD = 4;
  localparam int BC = 1;
`ifdef SEG_SCAN_BLANK_EN
  localparam bit BLK = 1'b1;
`else
  localparam bit BLK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [4*ND-1:0] digits_in;
  logic [ND-1:0] dec_mask;
  logic          load;
  logic [3:0]    dig_sel;
  logic          dec_on;
  logic [7:0]    seven_seg_in;
  logic [7:0]    seg_out;
  logic [ND-1:0] an_out;
  logic          frame_done;

  int total = 0;
  int bad   = 0;

  logic [13:0] exp_q[$];
  bit          mon_en = 1'b0;
  logic [ND-1:0] prev_an = '0;

  logic [4*ND-1:0] m_sh_d, m_st_d;
  logic [ND-1:0]   m_sh_m, m_st_m;
  bit              m_pend;

  seg_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .dec_mask(dec_mask),
    .load(load), .dig_sel(dig_sel), .dec_on(dec_on),
    .seven_seg_in(seven_seg_in), .seg_out(seg_out), .an_out(an_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Converter model: {dp, g, f, e, d, c, b, a}, active-high.
  function automatic logic [7:0] conv(input logic [3:0] d, input logic dp);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return {dp, s};
  endfunction

  always_comb seven_seg_in = conv(dig_sel, dec_on);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: each new non-zero enable is one slot display; compare it with
  // the oldest queued expectation.
  always @(negedge clk) begin
    logic [13:0] e;
    if (mon_en && an_out != prev_an && an_out != '0) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL slot_display actual=an %b seg %h required=nothing queued", an_out, seg_out);
      end else begin
        e = exp_q.pop_front();
        if ({an_out, seg_out} !== e) begin
          bad++;
          $display("FAIL slot_display actual=an %b seg %h required=an %b seg %h",
                   an_out, seg_out, e[13:8], e[7:0]);
        end
      end
    end
    prev_an = an_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_sh_d = '0; m_sh_m = '0; m_st_d = '0; m_st_m = '0; m_pend = 1'b0;
  endtask

  // One frame (or its first stop_at cycles) starting #1 after the edge that
  // enters slot 0. Up to two loads at frame-relative cycles la/lb (-1 = none).
  task automatic run_frame(input bit first,
                           input int la, input logic [23:0] da, input logic [5:0] ma,
                           input int lb, input logic [23:0] db, input logic [5:0] mb,
                           input int stop_at);
    logic [23:0] fd, byp_d;
    logic [5:0]  fm, byp_m, ea;
    bit          byp;
    fd = m_sh_d; fm = m_sh_m; byp = 1'b0; byp_d = '0; byp_m = '0;
    for (int s = 0; s < ND; s++)
      exp_q.push_back({6'(1 << s), conv(fd[4*s +: 4], fm[s])});
    for (int j = 0; j < stop_at; j++) begin
      int sl, ps, pd;
      sl = j / SD;
      chk("dig_sel", 32'(dig_sel), 32'(fd[4*sl +: 4]));
      chk("dec_on", 32'(dec_on), 32'(fm[sl]));
      if (j == 0) begin
        ea = first ? 6'b000000 : 6'b100000;
      end else begin
        ps = (j - 1) / SD;
        pd = (j - 1) % SD;
        ea = (BLK && pd < BC) ? 6'b000000 : 6'(1 << ps);
      end
      chk("an_out", 32'(an_out), 32'(ea));
      chk("frame_done", 32'(frame_done), 32'(j == ND*SD-1));
      if (j == la || j == lb) begin
        digits_in = (j == la) ? da : db;
        dec_mask  = (j == la) ? ma : mb;
        load = 1'b1;
        if (j == ND*SD-1) begin
          byp = 1'b1; byp_d = digits_in; byp_m = dec_mask;
        end else begin
          m_st_d = digits_in; m_st_m = dec_mask; m_pend = 1'b1;
        end
      end
      tick();
      load = 1'b0;
    end
    if (stop_at == ND*SD) begin
      if (byp) begin
        m_sh_d = byp_d; m_sh_m = byp_m; m_pend = 1'b0;
      end else if (m_pend) begin
        m_sh_d = m_st_d; m_sh_m = m_st_m; m_pend = 1'b0;
      end
    end
  endtask

  task automatic reset_and_check();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_dig_sel", 32'(dig_sel), 32'h0);
    chk("rst_dec_on", 32'(dec_on), 32'h0);
    chk("rst_seg_out", 32'(seg_out), 32'h0);
    chk("rst_an_out", 32'(an_out), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    exp_q.delete();
    model_reset();
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; digits_in = '0; dec_mask = '0;
    model_reset();
    tick();
    reset_and_check();
    mon_en = 1'b1;
    // zeros shown; load 1..6 with dp on digit 2
    run_frame(1'b1, 5, 24'h654321, 6'b000100, -1, '0, '0, ND*SD);
    // full scan of 1..6; load 9s at slot 2 (must not disturb this frame)
    run_frame(1'b0, 9, 24'h999999, 6'b000000, -1, '0, '0, ND*SD);
    // 9s; two loads, the second (with out-of-range digits) wins
    run_frame(1'b0, 3, 24'h111111, 6'b000001, 15, 24'hF0FA82, 6'b100001, ND*SD);
    // latest-wins frame; pending load then boundary bypass
    run_frame(1'b0, 10, 24'h222222, 6'b111111, ND*SD-1, 24'h314159, 6'b010010, ND*SD);
    // bypass value shown immediately; next boundary must not bring back 222222
    run_frame(1'b0, -1, '0, '0, -1, '0, '0, ND*SD);
    run_frame(1'b0, -1, '0, '0, -1, '0, '0, ND*SD);
    // pending load, then reset at slot 3: the load is lost
    run_frame(1'b0, 5, 24'h777777, 6'b111111, -1, '0, '0, 13);
    reset_and_check();
    run_frame(1'b1, -1, '0, '0, -1, '0, '0, ND*SD);
    run_frame(1'b0, -1, '0, '0, -1, '0, '0, ND*SD);
    mon_en = 1'b0;
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed display scanner for the 6-digit timer/stopwatch. It shares a single `dig_to_seven_seg` converter across all digit positions by stepping through the digits one at a time. For each digit it presents the BCD value and decimal-point flag to the converter, registers the returned segment pattern, and drives a one-hot digit enable. The count logic publishes digits through a load strobe; new values take effect only at frame boundaries, so a displayed frame never mixes old and new digits.

## Interface
- `NUM_DIGITS`, 6, number of digit positions scanned (≥2)
- `SCAN_DIV`, 50000, clock cycles per digit slot (≥2)
- `BLANK_CYCLES`, 500, blanked cycles at the start of each slot when blanking is compiled in (< `SCAN_DIV`)

Ports:
- `clk` in 1: single clock; all state changes on its rising edge
- `rst` in 1: reset is synchronous and active-high
- `digits_in` in 4×NUM_DIGITS: BCD digits; bits [3:0] = digit 0 (rightmost)
- `dec_mask` in NUM_DIGITS: decimal-point request per digit
- `load` in 1: one-cycle strobe that captures `digits_in`/`dec_mask` into staging
- `dig_sel` out 4: to converter `dig_in`
- `dec_on` out 1: to converter `dec_on`
- `seven_seg_in` in 8: from converter `seven_seg_out`, combinational in `dig_sel`/`dec_on`
- `seg_out` out 8: registered segment pattern to the pads
- `an_out` out NUM_DIGITS: one-hot digit enable, active-high; all-zero = blank
- `frame_done` out 1: one-cycle pulse on the last cycle of every frame

## Operation
- Registers:
  - `div_cnt` counts 0..SCAN_DIV-1
  - `slot` counts 0..NUM_DIGITS-1
  - staging and shadow copies of digits and dp mask
  - `load_pend` flag
- `div_cnt` increments every cycle. When it is at SCAN_DIV-1, it wraps to 0 and `slot` advances. `slot` wraps from NUM_DIGITS-1 to 0.
- Frame boundary is the cycle with `slot`=NUM_DIGITS-1 and `div_cnt`=SCAN_DIV-1:
  - `frame_done`=1 on that cycle
  - if `load_pend`, staging is copied to shadow and `load_pend` is cleared
- On `load`, staging captures the inputs and `load_pend` is set. A later load before the boundary overwrites staging (latest wins).
- `load` on the boundary cycle bypasses staging: that cycle's `digits_in`/`dec_mask` go straight into shadow and `load_pend` ends clear.
- `dig_sel`/`dec_on` are registered from shadow[`slot`'s next value]. They therefore change on the same edge that `slot` changes.
- `seg_out` registers `seven_seg_in` each cycle. `an_out` registers `1<<slot`, or blank (see Configuration).
- Digit values 10–15 pass through unchanged; decoding them is the converter's job.
- States:
  - RESET (`rst` high)
  - SCAN (normal stepping)
  - BLANK sub-phase of SCAN, only when blanking is compiled in

## Timing
- Reset values (cycle after `rst` sampled high):
  - `dig_sel`=0, `dec_on`=0, `seg_out`=8'h00, `an_out`=0, `frame_done`=0
  - `div_cnt`=0, `slot`=0, staging/shadow=0, `load_pend`=0
- `rst` asserted mid-frame aborts the scan immediately. A pending load is lost.
- First cycle after `rst` falls: `div_cnt`=0, `slot`=0.
- Latency: `seg_out` and `an_out` lag `dig_sel` by exactly 1 cycle. Both update on the same edge, so pattern and enable never mismatch.
- Slot length is exactly SCAN_DIV cycles. Frame length is NUM_DIGITS×SCAN_DIV cycles.
- Load-to-display latency: the first `an_out` for slot 0 of the frame after the next boundary, plus 1 cycle.

## Configuration
- `SEG_SCAN_BLANK_EN` defined:
  - `an_out`=0 while the registered `div_cnt` < BLANK_CYCLES in each slot (anti-ghosting)
  - one-hot for the remaining SCAN_DIV−BLANK_CYCLES cycles
- Not defined:
  - BLANK_CYCLES is ignored
  - `an_out` is one-hot for the full slot from the first post-reset output cycle
  - no gaps between slots

## Test plan
(All use SCAN_DIV=4, BLANK_CYCLES=1, NUM_DIGITS=6, with a real `dig_to_seven_seg` instance in the loop.)
- Reset mid-frame: pulse `rst` at slot 3 → next cycle all outputs 0. After release, `dig_sel` walks slot 0..5, each held 4 cycles.
- Full scan: load digits 1,2,3,4,5,6 plus `dec_mask`=6'b000100, then wait one boundary → `an_out` cycles 000001..100000 with `seg_out` equal to the converter pattern for each digit. The dp bit is set only while `an_out`=000100.
- Frame atomicity: load 9s mid-frame (slot 2) → slots 2–5 still show old digits. Slot 0 of the next frame shows 9. `frame_done` pulses once every 24 cycles.
- Latest-wins and boundary bypass: two loads in one frame → only the second is displayed. A load on the `frame_done` cycle → visible in the immediately following slot 0.
- Blanking: with `SEG_SCAN_BLANK_EN` → `an_out`=0 for cycle 0 of each slot and one-hot for cycles 1–3. Without it → no zero cycles after the first output.
- Out-of-range digit 4'hF → passed unchanged on `dig_sel`. `seg_out` equals the converter's output for F.
